// File: rtl/apb_reg_slave_if.sv
// APB responder bus bundle: setup/access request from the bridge side,
// ready/error/read-data response from the register slave.
interface apb_reg_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready_x;
    logic              pslverr_x;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready_x,
        input  pslverr_x
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready_x,
        output pslverr_x
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register slave: word-addressed bank with read-only ID at word 0,
// programmable wait states, registered ready/error/read-data response.
// Ports: hclk, hreset_n (async active-low), bus (APB slave modport),
// reg1_out (live value of word 1).
module apb_reg_slave #(
    parameter int NUM_REGS       = 16,
    parameter int WAIT_CYCLES    = 0,
    parameter int PADDR_WIDTH    = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter logic [APB_DATA_WIDTH-1:0] ID_VALUE = 32'h4150_4231
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    apb_reg_slave_if.slave            bus,
    output logic [APB_DATA_WIDTH-1:0] reg1_out
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PADDR_WIDTH:0] ADDR_LIMIT =
        (PADDR_WIDTH+1)'(4 * NUM_REGS);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef logic [APB_DATA_WIDTH-1:0] word_t;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic       write_q, write_d;
    logic       err_q, err_d;
    word_t      wdata_q, wdata_d;
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;
    word_t      prdata_q, prdata_d;
    word_t      regs_q [NUM_REGS];
    word_t      regs_d [NUM_REGS];

    logic             setup;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    word_t            word_at_req;
    word_t            word_at_lat;

    assign setup   = bus.psel & ~bus.penable;
    assign req_idx = bus.paddr[IDX_W+1:2];

    // Misaligned, out of range (any upper bit counts) or write to the ID.
    assign req_err = (|bus.paddr[1:0])
                   | ({1'b0, bus.paddr} >= ADDR_LIMIT)
                   | (bus.pwrite & (req_idx == '0));

    // Word 0 has no storage; it always reads back the ID constant.
    assign word_at_req = (req_idx == '0) ? ID_VALUE : regs_q[req_idx];
    assign word_at_lat = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        regs_d    = regs_q;

        unique case (state_q)
            S_IDLE: begin
                if (setup) begin
                    idx_d   = req_idx;
                    write_d = bus.pwrite;
                    err_d   = req_err;
                    wdata_d = bus.pwdata;
                    if (NO_WAIT) begin
                        // Response must be registered on this same edge.
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = req_err;
                        if (!bus.pwrite && !req_err) begin
                            prdata_d = word_at_req;
                        end
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    if (!write_q && !err_q) begin
                        prdata_d = word_at_lat;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (write_q && !err_q) begin
                    regs_d[idx_q] = wdata_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        regs_d[0] = '0;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign bus.pready_x  = pready_q;
    assign bus.pslverr_x = pslverr_q;
    assign bus.prdata    = prdata_q;
    assign reg1_out      = regs_q[1];

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB responder (slave_x) sitting on the far side of the AHB-to-APB bridge: it accepts APB setup/access phases driven by the bridge's `psel_en`/`paddr`/`penable`/`pwrite`/`pwdata` and returns `pready_x`, `pslverr_x` and read data. It contains a small word-addressed register bank with a read-only ID word and a programmable number of wait states. It is the reference target used to exercise the bridge's wait, success and error paths.

## Interface
- `NUM_REGS`, 16: number of 32-bit words; index 0 is the read-only ID, 1..NUM_REGS-1 are read/write.
- `WAIT_CYCLES`, 0: wait states inserted before `pready_x` (0..15).
- `ID_VALUE`, 32'h4150_4231: constant returned by word 0.
- `hclk` in 1: system clock, all logic on rising edge.
- `hreset_n` in 1: asynchronous, active-low reset.
- `psel` in 1: APB select (driven by the bridge's `psel_en`).
- `penable` in 1: APB enable.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in `PADDR_WIDTH`: byte address.
- `pwdata` in `APB_DATA_WIDTH`: write data.
- `prdata` out `APB_DATA_WIDTH`: read data, valid while `pready_x`=1 on a read.
- `pready_x` out 1: transfer complete.
- `pslverr_x` out 1: transfer error, qualified by `pready_x`.
- `reg1_out` out `APB_DATA_WIDTH`: live value of word 1 (control output).

## Operation
- States: IDLE, WAIT, RESP. All outputs registered.
- IDLE: on edge with `psel`=1, `penable`=0 (setup phase): latch `paddr`, `pwrite`, `pwdata`; compute error flag; go RESP if `WAIT_CYCLES`=0, else load counter=`WAIT_CYCLES`, go WAIT. `penable`=1 seen in IDLE without a preceding setup is ignored.
- WAIT: `pready_x`=0. If `psel`=0: abort to IDLE, no write, no response. Else if counter=1 go RESP, else decrement.
- RESP: `pready_x`=1 for exactly one cycle, `pslverr_x`=error flag, `prdata`=read word (0 on write or error). On leaving RESP, a non-error write commits latched `pwdata` to the addressed word. Always returns to IDLE.
- Error flag set when: `paddr[1:0]`≠0; `paddr` ≥ 4·`NUM_REGS` (any upper bits set counts as out of range); write to word 0. Errored transfers never modify any register.
- Word index = `paddr` >> 2; only low clog2(`NUM_REGS`) index bits select after range check.
- Read of word 0 returns `ID_VALUE`; writes to words 1..N-1 are full-width, no byte strobes.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, `pready_x`=0, `pslverr_x`=0, `prdata`=0, words 1..N-1 = 0, `reg1_out`=0.
- Setup in cycle T → `pready_x`=1 in cycle T+1+`WAIT_CYCLES`; access phase lasts `WAIT_CYCLES`+1 cycles.
- Written value visible on `reg1_out` and to reads from the cycle after RESP.
- Back-to-back: next setup allowed in the cycle after RESP; no idle cycle required.
- `pready_x` low in every non-RESP cycle; `pslverr_x` and `prdata` forced 0 when `pready_x`=0.
- Reset asserted mid-transfer: transfer dropped, no write committed, outputs to reset values immediately.
- Read-after-write to same word back-to-back returns the new value.

## Test plan
- `WAIT_CYCLES`=0: write 32'hDEAD_BEEF to 0x04, then read 0x04 -> `pready_x` high one cycle after each setup, `pslverr_x`=0, read `prdata`=32'hDEAD_BEEF, `reg1_out`=32'hDEAD_BEEF.
- `WAIT_CYCLES`=3: read 0x00 -> `pready_x` low 3 access cycles, high on 4th, `prdata`=32'h4150_4231.
- Errors: write 0x00, write 0x06, read 0x40 (N=16) -> each `pslverr_x`=1 with `pready_x`, `prdata`=0; subsequent read of 0x04 unchanged.
- Abort: `WAIT_CYCLES`=3, write 0x08 setup, drop `psel` in 2nd access cycle -> no `pready_x`, read 0x08 returns 0.
- Back-to-back through bridge: AHB write 0x0C=1 followed immediately by read 0x0C -> bridge reaches WRITE_SUCCESS then READ_SUCCESS, read data 1.
- Reset mid-WAIT during write 0x04 -> all outputs 0 instantly, read 0x04 after release returns 0.
